// File: rtl/risc_v_pkg.sv
// Shared types and widths for the integer register-file writeback path.
package risc_v_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/risc_v_wb_unit_hold_slot.sv
// One-entry holding buffer for a writeback producer; ready stays high while
// the entry is empty or is being drained this cycle.
module wb_hold_slot #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [REG_AW-1:0] rd,
    input  logic [XLEN-1:0]   data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic [REG_AW-1:0] slot_rd,
    output logic [XLEN-1:0]   slot_data
);

    logic load;

    assign ready = !full || grant;
    // Writes to x0 complete the handshake but never occupy the slot.
    assign load  = valid && ready && (rd != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload needs no reset; it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (load) begin
            slot_rd   <= rd;
            slot_data <= data;
        end
    end

endmodule

// File: rtl/risc_v_wb_unit.sv
// Writeback unit: round-robin merge of ALU and LSU results onto the register
// file write port, plus a pending-write scoreboard for hazard detection.
module risc_v_wb_unit #(
    parameter int XLEN   = risc_v_pkg::XLEN,
    parameter int REG_AW = risc_v_pkg::REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_AW-1:0]    alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_AW-1:0]    lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic                 issue_valid,
    input  logic [REG_AW-1:0]    issue_rd,
    output logic                 rf_wen,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [2**REG_AW-1:0] pending
);

    localparam int NREG = 2**REG_AW;

    logic                alu_full, lsu_full;
    logic                grant_alu, grant_lsu;
    logic [REG_AW-1:0]   alu_slot_rd, lsu_slot_rd;
    logic [XLEN-1:0]     alu_slot_data, lsu_slot_data;
    risc_v_pkg::wb_src_e rr_prio;
    logic [NREG-1:0]     pend_set, pend_clr, pend_q;

    wb_hold_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_alu_slot (
        .clk       (clk),
        .rst       (rst),
        .valid     (alu_valid),
        .rd        (alu_rd),
        .data      (alu_data),
        .grant     (grant_alu),
        .ready     (alu_ready),
        .full      (alu_full),
        .slot_rd   (alu_slot_rd),
        .slot_data (alu_slot_data)
    );

    wb_hold_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_lsu_slot (
        .clk       (clk),
        .rst       (rst),
        .valid     (lsu_valid),
        .rd        (lsu_rd),
        .data      (lsu_data),
        .grant     (grant_lsu),
        .ready     (lsu_ready),
        .full      (lsu_full),
        .slot_rd   (lsu_slot_rd),
        .slot_data (lsu_slot_data)
    );

    // Grant looks only at occupancy, so ready never depends on valid.
    assign grant_alu = alu_full && (!lsu_full || rr_prio == risc_v_pkg::WB_SRC_ALU);
    assign grant_lsu = lsu_full && !grant_alu;

    // rr_prio names the source that wins the next conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_prio <= risc_v_pkg::WB_SRC_ALU;
        end else if (grant_alu) begin
            rr_prio <= risc_v_pkg::WB_SRC_LSU;
        end else if (grant_lsu) begin
            rr_prio <= risc_v_pkg::WB_SRC_ALU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_alu) begin
            rf_wen   <= 1'b1;
            rf_waddr <= alu_slot_rd;
            rf_wdata <= alu_slot_data;
        end else if (grant_lsu) begin
            rf_wen   <= 1'b1;
            rf_waddr <= lsu_slot_rd;
            rf_wdata <= lsu_slot_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_valid) begin
            pend_set = NREG'(1) << issue_rd;
        end
        if (rf_wen) begin
            pend_clr = NREG'(1) << rf_waddr;
        end
    end

    // Set is applied after clear so a same-edge issue keeps the bit; bit 0 is masked off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= ((pend_q & ~pend_clr) | pend_set) & ~NREG'(1);
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_risc_v_wb_unit.sv
// Self-checking bench for risc_v_wb_unit: vector table, directed corner
// sequences and a per-source writeback scoreboard.
module tb_risc_v_wb_unit;
    import risc_v_pkg::*;

    logic              clk;
    logic              rst;
    logic              alu_valid, lsu_valid, issue_valid;
    logic              alu_ready, lsu_ready;
    logic [REG_AW-1:0] alu_rd, lsu_rd, issue_rd;
    logic [XLEN-1:0]   alu_data, lsu_data;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [31:0]       pending;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    wb_req_t alu_q[$];
    wb_req_t lsu_q[$];

    typedef struct {
        logic              is_lsu;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              exp_wen;
    } vec_t;

    vec_t vecs[6];

    logic [REG_AW-1:0] last_addr;
    logic [XLEN-1:0]   last_data;

    risc_v_wb_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are recorded per source, writes must match a source head in order.
    always @(negedge clk) begin
        wb_req_t got;
        wb_req_t exp;
        if (rst) begin
            alu_q.delete();
            lsu_q.delete();
        end else begin
            if (rf_wen) begin
                wr_count++;
                got = '{rd: rf_waddr, data: rf_wdata};
                if (alu_q.size() > 0 && alu_q[0] == got) begin
                    exp = alu_q.pop_front();
                end else if (lsu_q.size() > 0 && lsu_q[0] == got) begin
                    exp = lsu_q.pop_front();
                end else if (alu_q.size() > 0) begin
                    exp = alu_q[0];
                end else if (lsu_q.size() > 0) begin
                    exp = lsu_q[0];
                end else begin
                    exp = '0;
                end
                check("sb_write", 64'(got), 64'(exp));
            end
            if (alu_valid && alu_ready && alu_rd != '0) alu_q.push_back('{rd: alu_rd, data: alu_data});
            if (lsu_valid && lsu_ready && lsu_rd != '0) lsu_q.push_back('{rd: lsu_rd, data: lsu_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 1'b1};
        vecs[1] = '{1'b1, 5'd9,  32'h12345678, 1'b1};
        vecs[2] = '{1'b0, 5'd31, 32'hA5A5A5A5, 1'b1};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[4] = '{1'b0, 5'd0,  32'h00000001, 1'b0};
        vecs[5] = '{1'b1, 5'd31, 32'h00000000, 1'b1};

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        last_addr = '0; last_data = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_wen", rf_wen, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_pending", pending, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_lsu_ready", lsu_ready, 1);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_lsu) begin
                lsu_valid = 1'b1; lsu_rd = vecs[i].rd; lsu_data = vecs[i].data;
            end else begin
                alu_valid = 1'b1; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
            end
            tick();
            alu_valid = 1'b0;
            lsu_valid = 1'b0;
            check("vec_pre_wen", rf_wen, 0);
            tick();
            check("vec_wen", rf_wen, vecs[i].exp_wen);
            if (vecs[i].exp_wen) begin
                last_addr = vecs[i].rd;
                last_data = vecs[i].data;
            end
            check("vec_waddr", rf_waddr, last_addr);
            check("vec_wdata", rf_wdata, last_data);
            tick();
            check("vec_post_wen", rf_wen, 0);
        end

        // x0 result plus issue to x0.
        lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = '0;
        tick();
        lsu_valid = 1'b0; issue_valid = 1'b0;
        check("x0_pending", pending, 0);
        tick();
        check("x0_wen", rf_wen, 0);

        // Two-source conflict, then a repeated conflict that the LSU must win.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        check("cf_alu_ready0", alu_ready, 1);
        check("cf_lsu_ready0", lsu_ready, 1);
        tick();
        check("cf_wen0", rf_wen, 0);
        check("cf_alu_ready1", alu_ready, 1);
        check("cf_lsu_ready1", lsu_ready, 0);
        alu_rd = 5'd10; alu_data = 32'h33;
        lsu_valid = 1'b0;
        tick();
        alu_valid = 1'b0;
        check("cf_wen1", rf_wen, 1);
        check("cf_addr1", rf_waddr, 3);
        check("cf_data1", rf_wdata, 32'h11);
        check("cf_lsu_ready2", lsu_ready, 1);
        check("cf_alu_ready2", alu_ready, 0);
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h44;
        tick();
        lsu_valid = 1'b0;
        check("cf_wen2", rf_wen, 1);
        check("cf_addr2", rf_waddr, 4);
        check("cf_data2", rf_wdata, 32'h22);
        check("cf_lsu_ready3", lsu_ready, 0);
        tick();
        check("cf_addr3", rf_waddr, 10);
        check("cf_data3", rf_wdata, 32'h33);
        tick();
        check("cf_addr4", rf_waddr, 11);
        check("cf_data4", rf_wdata, 32'h44);
        tick();
        check("cf_wen5", rf_wen, 0);

        // Scoreboard: set, hold, clear on writeback.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_set", pending, 32'h80);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        check("sb_hold0", pending, 32'h80);
        tick();
        check("sb_wb_wen", rf_wen, 1);
        check("sb_wb_addr", rf_waddr, 7);
        check("sb_hold1", pending, 32'h80);
        tick();
        check("sb_clear", pending, 0);

        // Scoreboard: issue on the writeback edge keeps the bit.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        tick();
        alu_valid = 1'b0;
        tick();
        check("sb2_wb_addr", rf_waddr, 7);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb2_set_wins", pending, 32'h80);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h79;
        tick();
        alu_valid = 1'b0;
        tick();
        tick();
        check("sb2_clear", pending, 0);

        // Back-to-back ALU stream.
        for (int i = 1; i <= 8; i++) begin
            alu_valid = 1'b1; alu_rd = REG_AW'(i); alu_data = 32'h100 + 32'(i);
            check("st_ready", alu_ready, 1);
            tick();
            if (i > 1) begin
                check("st_wen", rf_wen, 1);
                check("st_addr", rf_waddr, i - 1);
                check("st_data", rf_wdata, 32'h100 + 32'(i - 1));
            end
        end
        alu_valid = 1'b0;
        tick();
        check("st_addr_last", rf_waddr, 8);
        tick();
        check("st_idle", rf_wen, 0);

        // Same stream interrupted by reset after the fourth write.
        for (int i = 1; i <= 5; i++) begin
            alu_valid = 1'b1; alu_rd = REG_AW'(i); alu_data = 32'h200 + 32'(i);
            tick();
        end
        check("rs_addr4", rf_waddr, 4);
        check("rs_wen4", rf_wen, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_wen_async", rf_wen, 0);
        check("rs_waddr_async", rf_waddr, 0);
        alu_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wr_count = 0;
        repeat (12) tick();
        check("rs_no_writes", wr_count, 0);
        check("rs_pending", pending, 0);
        check("sb_alu_empty", alu_q.size(), 0);
        check("sb_lsu_empty", lsu_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
